// File: rtl/hub_pkg.sv
// Shared definitions for the nonce hub: nonce width, transmit FSM encoding
// and a saturating counter helper.
package hub_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_SEND    = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_e;

  // Adds a small per-cycle drop count to a 16-bit total, pinning at all ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [4:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {12'd0, inc};
    if (sum[16]) begin
      sat_add16 = 16'hFFFF;
    end else begin
      sat_add16 = sum[15:0];
    end
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous first-in first-out buffer with full/empty flags and occupancy.
// Writes while full and reads while empty are ignored.
module nonce_fifo
  import hub_pkg::*;
#(
  parameter int WIDTH      = NONCE_W,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  do_wr_s;
  logic                  do_rd_s;

  // Occupancy never exceeds DEPTH, so its MSB alone marks full.
  assign full    = level_r[DEPTH_LOG2];
  assign empty   = (level_r == {(DEPTH_LOG2 + 1){1'b0}});
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign do_wr_s = wr_en & ~full;
  assign do_rd_s = rd_en & ~empty;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2 + 1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/nonce_hub_fifo.sv
// Collects nonces from several sources via edge capture and round-robin
// arbitration into a FIFO, then hands them one at a time to serial_transmit.
module nonce_hub_fifo
  import hub_pkg::*;
#(
  parameter int SLAVES     = 4,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic [SLAVES-1:0]         new_nonces,
  output logic [NONCE_W-1:0]        golden_nonce,
  output logic                      serial_send,
  input  logic                      serial_busy,
  output logic [DEPTH_LOG2:0]       fifo_level,
  output logic [15:0]               drop_count
);

  localparam int PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  logic [SLAVES-1:0]  prev_nn_r;
  logic [SLAVES-1:0]  pending_r;
  logic [NONCE_W-1:0] hold_r [SLAVES];
  logic [PTR_W-1:0]   rr_ptr_r;
  tx_state_e          state_r;

  logic [SLAVES-1:0]  capture_s;
  logic [SLAVES-1:0]  grant_vec_s;
  logic [SLAVES-1:0]  drop_s;
  logic [4:0]         drop_n_s;
  logic               grant_s;
  logic [NONCE_W-1:0] grant_data_s;
  logic [PTR_W-1:0]   rr_next_s;
  logic [PTR_W-1:0]   idx_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [NONCE_W-1:0] fifo_head_s;
  tx_state_e          state_next_s;
  logic               load_s;

  assign capture_s = new_nonces & ~prev_nn_r;
  // A granted slave hands its old value to the FIFO, so its recapture is not a loss.
  assign drop_s    = capture_s & pending_r & ~grant_vec_s;

  // Round-robin search starting at rr_ptr; blocked entirely while the FIFO is full.
  always_comb begin
    grant_s      = 1'b0;
    grant_vec_s  = {SLAVES{1'b0}};
    grant_data_s = {NONCE_W{1'b0}};
    rr_next_s    = rr_ptr_r;
    idx_s        = {PTR_W{1'b0}};
    for (int k = 0; k < SLAVES; k++) begin
      idx_s = PTR_W'((int'(rr_ptr_r) + k) % SLAVES);
      if (!grant_s && !fifo_full_s && pending_r[idx_s]) begin
        grant_s            = 1'b1;
        grant_vec_s[idx_s] = 1'b1;
        grant_data_s       = hold_r[idx_s];
        rr_next_s          = PTR_W'((int'(idx_s) + 1) % SLAVES);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Number of nonces lost this cycle.
  always_comb begin
    drop_n_s = 5'd0;
    for (int i = 0; i < SLAVES; i++) begin
      drop_n_s = drop_n_s + {4'd0, drop_s[i]};
    end
  end

  // Edge detector history; all ones at reset so levels already high are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_nn_r <= {SLAVES{1'b1}};
    end else begin
      prev_nn_r <= new_nonces;
    end
  end

  // Per-source holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLAVES; i++) begin
        hold_r[i] <= {NONCE_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (capture_s[i]) begin
          hold_r[i] <= slave_nonces[i*NONCE_W +: NONCE_W];
        end
      end
    end
  end

  // Pending flags, arbitration pointer and loss counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r  <= {SLAVES{1'b0}};
      rr_ptr_r   <= {PTR_W{1'b0}};
      drop_count <= 16'd0;
    end else begin
      pending_r  <= (pending_r & ~grant_vec_s) | capture_s;
      rr_ptr_r   <= rr_next_s;
      drop_count <= sat_add16(drop_count, drop_n_s);
    end
  end

  nonce_fifo #(
    .WIDTH      (NONCE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (grant_s),
    .wr_data (grant_data_s),
    .rd_en   (load_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  // Transmit handshake: wait for busy to rise then fall before the next word.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (!fifo_empty_s && !serial_busy) begin
          state_next_s = TX_SEND;
          load_s       = 1'b1;
        end else begin
          state_next_s = TX_IDLE;
        end
      end
      TX_SEND: state_next_s = TX_WAIT_HI;
      TX_WAIT_HI: begin
        if (serial_busy) begin
          state_next_s = TX_WAIT_LO;
        end else begin
          state_next_s = TX_WAIT_HI;
        end
      end
      TX_WAIT_LO: begin
        if (!serial_busy) begin
          state_next_s = TX_IDLE;
        end else begin
          state_next_s = TX_WAIT_LO;
        end
      end
      default: state_next_s = TX_IDLE;
    endcase
  end

  // State register plus registered send strobe and output word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= TX_IDLE;
      serial_send  <= 1'b0;
      golden_nonce <= {NONCE_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      serial_send <= load_s;
      if (load_s) begin
        golden_nonce <= fifo_head_s;
      end
    end
  end

endmodule
